// File: rtl/ucsbece154b_pkg.sv
// Shared types and constants for the ucsbece154b prefetcher: FSM state
// encoding and the width of the optional stall counter.
package ucsbece154b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/ucsbece154b_credit_cnt.sv
// Credit counter for the downstream FIFO: starts full at MAX, one credit is
// taken per issued request and up to two are given back per cycle (pop plus
// a discarded flush response); the count saturates at MAX.
module ucsbece154b_credit_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         take,
  input  logic [1:0]   give,
  output logic [W-1:0] credits
);

  logic [W-1:0] credits_r;
  logic [W-1:0] credits_s;
  logic [W+1:0] sum_s;

  // Next credit value: net of take/give, clamped at MAX
  always_comb begin
    sum_s = {2'b00, credits_r} + {{W{1'b0}}, give} - {{(W + 1){1'b0}}, take};
    if (sum_s > (W + 2)'(MAX)) begin
      credits_s = W'(MAX);
    end else begin
      credits_s = sum_s[W-1:0];
    end
  end

  // Credit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_r <= W'(MAX);
    end else begin
      credits_r <= credits_s;
    end
  end

  assign credits = credits_r;

endmodule

// File: rtl/ucsbece154b_prefetch.sv
// Credit-based burst prefetcher: issues sequential read requests, forwards
// in-order responses to a downstream FIFO. Optional stall counter is built
// only when UCSBECE154B_PREFETCH_STATS_EN is defined.
module ucsbece154b_prefetch
  import ucsbece154b_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NR_ENTRIES = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic                   flush_i,
  output logic                   req_valid_o,
  output logic [ADDR_WIDTH-1:0]  req_addr_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]  rsp_data_i,
  output logic                   push_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  input  logic                   pop_seen_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int CW = $clog2(NR_ENTRIES + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [LEN_WIDTH-1:0]  rem_r, rem_s;
  logic [CW-1:0]         out_r, out_s;
  logic [CW-1:0]         credits_s;
  logic                  done_r, done_s;
  logic                  xfer_s, rsp_live_s, drop_s, start_acc_s;
  logic [1:0]            give_s;

  assign req_valid_o = (state_r == ISSUE) && (rem_r != '0) && (credits_s != '0);
  assign req_addr_o  = addr_r;
  assign xfer_s      = req_valid_o && req_ready_i;
  assign start_acc_s = (state_r == IDLE) && start_i && !flush_i;
  // Responses count against outstanding in every non-idle state; only
  // ISSUE/DRAIN forward them, FLUSH turns them back into credits.
  assign rsp_live_s  = rsp_valid_i && (state_r != IDLE);
  assign push_o      = rsp_valid_i && ((state_r == ISSUE) || (state_r == DRAIN));
  assign data_o      = push_o ? rsp_data_i : '0;
  assign drop_s      = rsp_valid_i && (state_r == FLUSH);
  assign give_s      = {1'b0, pop_seen_i} + {1'b0, drop_s};
  assign out_s       = out_r + CW'(xfer_s) - CW'(rsp_live_s);
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;

  ucsbece154b_credit_cnt #(.MAX(NR_ENTRIES)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .take    (xfer_s),
    .give    (give_s),
    .credits (credits_s)
  );

  // Next-state, address/length bookkeeping and completion pulse
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    rem_s   = rem_r;
    done_s  = 1'b0;
    if (xfer_s) begin
      addr_s = addr_r + STEP;
      rem_s  = rem_r - LEN_WIDTH'(1);
    end else begin
      addr_s = addr_r;
    end
    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          addr_s = addr_i;
          rem_s  = len_i;
          if (len_i != '0) begin
            state_s = ISSUE;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_s = (out_s != '0) ? FLUSH : IDLE;
        end else if (xfer_s && (rem_r == LEN_WIDTH'(1))) begin
          if (out_s == '0) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (flush_i) begin
          state_s = (out_s != '0) ? FLUSH : IDLE;
        end else if (out_s == '0) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      FLUSH: begin
        if (out_s == '0) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and burst bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      out_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      rem_r   <= rem_s;
      out_r   <= out_s;
      done_r  <= done_s;
    end
  end

`ifdef UCSBECE154B_PREFETCH_STATS_EN
  logic [STALL_CNT_W-1:0] stall_r;

  // Saturating count of cycles ISSUE waits on credits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= '0;
    end else if (start_acc_s) begin
      stall_r <= '0;
    end else if ((state_r == ISSUE) && (rem_r != '0) && (credits_s == '0) && (stall_r != '1)) begin
      stall_r <= stall_r + STALL_CNT_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt_o = stall_r;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ucsbece154b_prefetch.sv
// Self-checking bench for ucsbece154b_prefetch: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_ucsbece154b_prefetch;

  localparam int NR = 4;
`ifdef UCSBECE154B_PREFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i, req_ready_i, rsp_valid_i, pop_seen_i;
  logic [31:0] addr_i, rsp_data_i;
  logic [7:0]  len_i;
  logic        req_valid_o, push_o, busy_o, done_o;
  logic [31:0] req_addr_o, data_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  ucsbece154b_prefetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NR_ENTRIES(NR), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .flush_i(flush_i), .req_valid_o(req_valid_o), .req_addr_o(req_addr_o),
    .req_ready_i(req_ready_i), .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .push_o(push_o), .data_o(data_o), .pop_seen_i(pop_seen_i), .busy_o(busy_o),
    .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t mq[$];

  int tests = 0, fails = 0, cyc = 0, lat = 1, last_due = 0;
  bit chk_en = 1'b0, pop_want = 1'b0;

  // transaction-level model of the prefetcher and its FIFO
  bit m_busy, m_flushing, m_done;
  logic [31:0] m_base;
  int m_len, m_issued, m_out, m_credits, m_occ, m_stall;

  bit e_req_valid, e_push, e_busy, e_done;
  logic [31:0] e_addr, e_data;
  int e_stall;

  int n_push = 0, n_done = 0, n_rv = 0, last_push_cyc = 0, last_done_cyc = 0;
  logic [31:0] xa[$];
  int xc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_flushing = 0; m_done = 0; m_base = 32'h0; m_len = 0; m_issued = 0;
    m_out = 0; m_credits = NR; m_occ = 0; m_stall = 0;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("req_valid", req_valid_o, e_req_valid);
      if (e_req_valid) chk("req_addr", req_addr_o, e_addr);
      chk("push", push_o, e_push);
      chk("data", data_o, e_data);
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("stall_cnt", stall_cnt_o, e_stall);
      if (req_valid_o && req_ready_i) begin xa.push_back(req_addr_o); xc.push_back(cyc); end
      if (push_o) begin n_push++; last_push_cyc = cyc; end
      if (done_o) begin n_done++; last_done_cyc = cyc; end
      if (req_valid_o) n_rv++;
    end
  end

  task automatic step();
    bit xfer, rspc, drop, bo, fo;
    rsp_t r;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mq[0].data;
      mq.delete(0);
    end
    pop_seen_i  = pop_want && (m_occ > 0);
    e_req_valid = m_busy && !m_flushing && (m_issued < m_len) && (m_credits > 0);
    e_addr      = m_base + 32'(m_issued * 4);
    e_push      = rsp_valid_i && m_busy && !m_flushing;
    e_data      = e_push ? rsp_data_i : 32'h0;
    e_busy      = m_busy;
    e_done      = m_done;
    e_stall     = STATS ? m_stall : 0;
    chk_en      = 1'b1;
    @(posedge clk);
    xfer = e_req_valid && req_ready_i;
    rspc = rsp_valid_i && m_busy;
    drop = rspc && m_flushing;
    bo = m_busy;
    fo = m_flushing;
    if (m_busy && !m_flushing && m_issued < m_len && m_credits == 0 && m_stall < 65535) m_stall++;
    if (xfer) begin
      r.data = $urandom;
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      mq.push_back(r);
      m_issued++;
      m_out++;
    end
    if (rspc) m_out--;
    if (e_push) m_occ++;
    if (pop_seen_i) m_occ--;
    m_credits = m_credits - int'(xfer) + int'(pop_seen_i) + int'(drop);
    if (m_credits > NR) m_credits = NR;
    m_done = 0;
    if (!bo) begin
      if (start_i && !flush_i) begin
        m_base = addr_i; m_len = int'(len_i); m_issued = 0; m_stall = 0;
        if (m_len == 0) m_done = 1; else m_busy = 1;
      end
    end else if (!fo && flush_i) begin
      if (m_out > 0) m_flushing = 1; else m_busy = 0;
    end else if (fo) begin
      if (m_out == 0) begin m_busy = 0; m_flushing = 0; end
    end else if (m_issued == m_len && m_out == 0) begin
      m_busy = 0; m_done = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic run_until_idle(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!m_busy && !m_done && mq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout: not idle after %0d cycles (cycle %0d)", max, cyc);
    end
  endtask

  task automatic drain_fifo();
    pop_want = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_occ == 0) break;
      step();
    end
    pop_want = 1'b0;
  endtask

  task automatic start_burst(input logic [31:0] a, input logic [7:0] l);
    addr_i = a; len_i = l; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, p0, d0, r0, cs;
    rst = 1'b1; start_i = 0; flush_i = 0; req_ready_i = 0; rsp_valid_i = 0;
    pop_seen_i = 0; addr_i = 0; len_i = 0; rsp_data_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_push", push_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_stall", stall_cnt_o, 16'h0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // basic burst
    lat = 1; req_ready_i = 1'b1; xa.delete(); xc.delete(); p0 = n_push;
    start_burst(32'h1000, 8'd3);
    run_until_idle(30);
    chk("basic_nreq", xa.size(), 3);
    if (xa.size() >= 3) begin
      chk("basic_addr0", xa[0], 32'h1000);
      chk("basic_addr1", xa[1], 32'h1004);
      chk("basic_addr2", xa[2], 32'h1008);
      chk("basic_consec", xc[2] - xc[0], 2);
    end
    chk("basic_pushes", n_push - p0, 3);
    chk("basic_done_at", last_done_cyc, last_push_cyc + 1);
    drain_fifo();

    // credit stall
    xa.delete(); d0 = n_done;
    start_burst(32'h1100, 8'd6);
    repeat (11) step();
    chk("stall_nreq", xa.size(), 4);
    chk("stall_valid", req_valid_o, 1'b0);
    chk("stall_count", stall_cnt_o, STATS ? 16'd7 : 16'd0);
    pop_want = 1'b1;
    repeat (2) step();
    pop_want = 1'b0;
    run_until_idle(40);
    chk("stall_total_req", xa.size(), 6);
    chk("stall_done", n_done - d0, 1);
    drain_fifo();

    // backpressure
    xa.delete(); req_ready_i = 1'b0;
    start_burst(32'h2000, 8'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", req_valid_o, 1'b1);
      chk("bp_addr", req_addr_o, 32'h2000);
      step();
    end
    n0 = xa.size();
    req_ready_i = 1'b1;
    step();
    chk("bp_xfer_cnt", xa.size() - n0, 1);
    if (xa.size() > n0) chk("bp_xfer_addr", xa[n0], 32'h2000);
    chk("bp_no_early", n0, 0);
    run_until_idle(30);
    drain_fifo();

    // flush with two outstanding
    lat = 6; xa.delete(); p0 = n_push; d0 = n_done;
    start_burst(32'h3000, 8'd4);
    repeat (2) step();
    req_ready_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    run_until_idle(40);
    chk("flush_nreq", xa.size(), 2);
    chk("flush_pushes", n_push - p0, 0);
    chk("flush_done", n_done - d0, 0);
    chk("flush_busy", busy_o, 1'b0);
    // all four credits must be back
    lat = 30; xa.delete(); req_ready_i = 1'b1;
    start_burst(32'h4000, 8'd5);
    repeat (8) step();
    chk("flush_credits", xa.size(), 4);
    pop_want = 1'b1;
    run_until_idle(100);
    pop_want = 1'b0;
    drain_fifo();

    // zero length
    lat = 1; d0 = n_done; r0 = n_rv; cs = cyc;
    start_burst(32'h5000, 8'd0);
    repeat (2) step();
    chk("zero_done", n_done - d0, 1);
    chk("zero_done_at", last_done_cyc, cs + 1);
    chk("zero_no_req", n_rv - r0, 0);

    // asynchronous reset mid-ISSUE
    lat = 3;
    start_burst(32'h6000, 8'd4);
    repeat (2) step();
    #2;
    rst = 1'b1; start_i = 0; flush_i = 0; req_ready_i = 0; rsp_valid_i = 0; pop_seen_i = 0;
    #1;
    chk("arst_valid", req_valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    model_reset();
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1; cyc++;
    p0 = n_push;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 0) break;
      step();
    end
    chk("arst_no_push", n_push - p0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start_i     = ($urandom_range(0, 2) == 0);
      addr_i      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      len_i       = 8'($urandom_range(0, 7));
      flush_i     = ($urandom_range(0, 24) == 0);
      req_ready_i = ($urandom_range(0, 3) != 0);
      pop_want    = 1'($urandom_range(0, 1));
      if (!m_busy) lat = $urandom_range(1, 4);
      step();
    end
    start_i = 1'b0; flush_i = 1'b0; req_ready_i = 1'b1; pop_want = 1'b1;
    run_until_idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_prefetch.md
UCSBECE154B_PREFETCH -- requirements
Module: ucsbece154b_prefetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of memory response data and FIFO push data.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of request addresses.
REQ-003 Parameter NR_ENTRIES, default 4, SHALL equal the depth of the downstream FIFO and set the initial credit count.
REQ-004 Parameter LEN_WIDTH, default 8, SHALL set the burst length width.
REQ-005 Ports SHALL be:
- clk  in  1  clock; one clock, all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  begin a burst.
- addr_i  in  ADDR_WIDTH  burst base byte address.
- len_i  in  LEN_WIDTH  number of beats.
- flush_i  in  1  abort the current burst.
- req_valid_o  out  1  memory read request valid.
- req_addr_o  out  ADDR_WIDTH  request address.
- req_ready_i  in  1  memory accepts the request.
- rsp_valid_i  in  1  in-order read response valid.
- rsp_data_i  in  DATA_WIDTH  response data.
- push_o  out  1  FIFO push strobe.
- data_o  out  DATA_WIDTH  FIFO push data.
- pop_seen_i  in  1  downstream FIFO popped one entry; returns one credit.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when a burst completes normally.
- stall_cnt_o  out  16  credit-stall cycle count (see Configuration).

Function
REQ-006 The FSM SHALL have the states IDLE, ISSUE, DRAIN and FLUSH.
REQ-007 IDLE with start_i=1 and flush_i=0 SHALL latch addr_i and len_i.
- len_i>0: next state ISSUE.
- len_i=0: done_o=1 on the next cycle, state stays IDLE, no request issued.
REQ-008 start_i outside IDLE SHALL be ignored.
REQ-009 In ISSUE, req_valid_o SHALL be 1 iff remaining>0 and credits>0.
REQ-010 A request SHALL transfer on req_valid_o and req_ready_i; req_addr_o SHALL hold stable while req_valid_o=1 and req_ready_i=0.
REQ-011 Each transfer SHALL add DATA_WIDTH/8 to the address, wrap modulo 2^ADDR_WIDTH, decrement remaining and increment outstanding.
REQ-012 When the last beat transfers, the next state SHALL be DRAIN.
REQ-013 DRAIN SHALL go to IDLE on the cycle outstanding reaches 0, with done_o=1 for exactly that following cycle.
- If the last response arrives in the same cycle as the last request, ISSUE SHALL go directly to IDLE with done_o.
REQ-014 In ISSUE or DRAIN, rsp_valid_i SHALL drive push_o=1 and data_o=rsp_data_i combinationally in the same cycle (zero latency), and SHALL decrement outstanding.
REQ-015 rsp_valid_i in IDLE SHALL be dropped: no push and no counter change.
REQ-016 Credits SHALL be an unsigned counter $clog2(NR_ENTRIES+1) bits wide, reset to NR_ENTRIES.
- -1 on a request transfer; +1 on pop_seen_i.
- A transfer and pop_seen_i in the same cycle SHALL leave credits unchanged.
- pop_seen_i at credits=NR_ENTRIES SHALL be ignored (saturate).
REQ-017 The sum of FIFO occupancy and outstanding requests SHALL never exceed NR_ENTRIES, so push_o never coincides with a full FIFO.
REQ-018 flush_i in ISSUE or DRAIN SHALL set req_valid_o=0 from the next cycle and move to FLUSH if outstanding after this cycle is >0, else to IDLE; no done_o is pulsed.
REQ-019 flush_i in IDLE SHALL be ignored; flush_i together with start_i in IDLE SHALL cancel the start.
REQ-020 In FLUSH, responses SHALL be discarded (push_o=0), each returning one credit and decrementing outstanding; FLUSH SHALL go to IDLE when outstanding reaches 0.
REQ-021 data_o SHALL be 0 whenever push_o=0.

Reset
REQ-022 Asserting rst SHALL, without waiting for a clock edge, set:
- state to IDLE;
- credits to NR_ENTRIES;
- outstanding, remaining, address and stall count to 0;
- req_valid_o, push_o, busy_o and done_o to 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; responses arriving after reset SHALL be dropped per REQ-015.

Configuration
REQ-024 Macro UCSBECE154B_PREFETCH_STATS_EN SHALL control the stall counter.
- Defined: stall_cnt_o counts cycles in ISSUE with remaining>0 and credits=0, saturating at 16'hFFFF and cleared on each accepted start.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Structure
REQ-025 Package ucsbece154b_pkg SHALL hold the FSM state enum typedef (IDLE, ISSUE, DRAIN, FLUSH) and the stall-counter width constant STALL_CNT_W=16.
REQ-026 The credit counter SHALL be the sub-module ucsbece154b_credit_cnt, with parameter MAX and inputs take/give.

Verification
REQ-027 The bench SHALL cover:
- Basic burst: reset, then start addr 0x1000, len 3, req_ready_i=1, response one cycle after each request -> req_addr_o 0x1000, 0x1004, 0x1008 on consecutive cycles; 3 pushes; done_o one cycle after the last response.
- Credit stall: len 6, NR_ENTRIES=4, no pops -> exactly 4 requests, then req_valid_o=0 (stall_cnt_o increments if enabled); two pop_seen_i pulses -> 2 more requests, then done_o.
- Backpressure: start addr 0x2000, req_ready_i=0 for 5 cycles -> req_valid_o=1 and req_addr_o=0x2000 held all 5 cycles; the transfer happens on the first cycle req_ready_i=1.
- Flush: flush_i with 2 outstanding -> FLUSH; 2 responses produce push_o=0; credits return to 4; state IDLE; done_o never asserted.
- Zero length: start with len 0 -> done_o next cycle, req_valid_o never 1.
- Async reset: rst asserted mid-ISSUE between clock edges -> req_valid_o=0 and busy_o=0 immediately; a later rsp_valid_i produces no push.
